rgb_fade_sequencer: RTL

RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

---
 rtl/rgb_fade_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - four-slot RGB colour fade/hold sequencer driving three PWM duties
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   wr_en, wr_addr, wr_data    colour slot write ({red, green, blue}, red in MSBs)
//   num_slots, loop            last slot index of the sequence, restart-at-slot-0 enable
//   start, stop                begin-sequence and abort pulses
//   busy, done                 sequence active, one-cycle end-of-sequence pulse
//   red_duty, green_duty, blue_duty   registered PWM duties, 0..2^R
module rgb_fade_sequencer #(
    parameter int R          = 8,
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [1:0]           wr_addr,
    input  logic [3*(R+1)-1:0]   wr_data,
    input  logic [1:0]           num_slots,
    input  logic                 loop,
    input  logic                 start,
    input  logic                 stop,
    output logic                 busy,
    output logic                 done,
    output logic [R:0]           red_duty,
    output logic [R:0]           green_duty,
    output logic [R:0]           blue_duty
);

    localparam int DW = R + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [DW-1:0] DUTY_MAX  = {1'b1, {R{1'b0}}};
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [1:0]      idx, idx_n;
    logic [TW-1:0]   tick_cnt;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic            done_n;
    logic            step_en;
    logic            tick;
    logic            at_target;

    logic [DW-1:0]   slot_r [4];
    logic [DW-1:0]   slot_g [4];
    logic [DW-1:0]   slot_b [4];

    logic [DW-1:0]   tgt_r, tgt_g, tgt_b;

    function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] v);
        return (v > DUTY_MAX) ? DUTY_MAX : v;
    endfunction

    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt);
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    // Target is read live so a write to the active slot retargets the fade immediately.
    assign tgt_r     = slot_r[idx];
    assign tgt_g     = slot_g[idx];
    assign tgt_b     = slot_b[idx];
    assign at_target = (red_duty == tgt_r) && (green_duty == tgt_g) && (blue_duty == tgt_b);
    assign tick      = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        hold_n  = hold_cnt;
        done_n  = 1'b0;
        step_en = 1'b0;
        if (stop) begin
            // Abort freezes duties where they are and never pulses done.
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = FADE;
                        idx_n   = 2'd0;
                    end
                end
                FADE: begin
                    if (tick) begin
                        if (at_target) begin
                            state_n = HOLD;
                            hold_n  = '0;
                        end else begin
                            step_en = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt != HOLD_LAST) begin
                            hold_n = hold_cnt + 1'b1;
                        end else if (idx < num_slots) begin
                            idx_n   = idx + 2'd1;
                            state_n = FADE;
                        end else if (loop) begin
                            idx_n   = 2'd0;
                            state_n = FADE;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= 2'd0;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            done       <= 1'b0;
            red_duty   <= '0;
            green_duty <= '0;
            blue_duty  <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= '0;
                slot_g[i] <= '0;
                slot_b[i] <= '0;
            end
        end else begin
            idx      <= idx_n;
            hold_cnt <= hold_n;
            done     <= done_n;

            // Counter sits at 0 whenever IDLE is current or next, so a fresh start
            // always sees its first tick TICK_DIV cycles after entering FADE.
            if ((state == IDLE) || (state_n == IDLE))
                tick_cnt <= '0;
            else if (tick_cnt == TICK_LAST)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            if (step_en) begin
                red_duty   <= step_toward(red_duty,   tgt_r);
                green_duty <= step_toward(green_duty, tgt_g);
                blue_duty  <= step_toward(blue_duty,  tgt_b);
            end

            if (wr_en) begin
                slot_r[wr_addr] <= clamp_duty(wr_data[3*DW-1:2*DW]);
                slot_g[wr_addr] <= clamp_duty(wr_data[2*DW-1:DW]);
                slot_b[wr_addr] <= clamp_duty(wr_data[DW-1:0]);
            end
        end
    end

endmodule
